uart_cmd_controller: RTL and testbench
======================================

# uart_cmd_controller

Frame-level command controller placed directly behind the 8N1 UART receiver (9600 baud, 100 MHz clock) in the temperature-control design. It consumes the receiver's byte stream (`rx_data`/`rx_valid`), assembles 4-byte command frames, checks them, and applies the result to the runtime configuration registers used by the control loop: setpoint, hysteresis and mode. Bad frames and stalled frames are discarded. Each discard is reported with a one-cycle error pulse and an error code.

## Interface
- `HEADER`, default 8'hA5: frame start byte.
- `SP_MIN`, default 10: lowest accepted setpoint, in °C.
- `SP_MAX`, default 50: highest accepted setpoint, in °C.
- `SP_RESET`, default 25: setpoint after reset.
- `HYST_RESET`, default 2: hysteresis after reset.
- `TIMEOUT_CYCLES`, default 1_000_000: inter-byte timeout in clk cycles (10 ms). Must be ≥ 2 and < 2^24.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte. Valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `setpoint`  out  8  target temperature in °C. Reset value `SP_RESET`.
- `hysteresis`  out  4  control band in °C. Reset value `HYST_RESET`.
- `mode`  out  2  operating mode: 0 = off, 1 = auto, 2 = force-on. Reset value 1.
- `cfg_update`  out  1  one-cycle pulse when a configuration register has been written. Reset value 0.
- `err_pulse`  out  1  one-cycle pulse when a frame is discarded. Reset value 0.
- `err_code`  out  2  cause of the last error: 1 = checksum, 2 = timeout, 3 = bad command or value. Holds its value until the next error. Reset value 0.
- `busy`  out  1  high while a frame is partially received (state ≠ IDLE). Reset value 0.

## Operation
- Frame format: `HEADER`, CMD, DATA, CHK.
  - CHK = (`HEADER` + CMD + DATA) mod 256.
- Commands:
  - CMD 8'h01: setpoint ← DATA. Legal range is `SP_MIN` ≤ DATA ≤ `SP_MAX`, inclusive.
  - CMD 8'h02: hysteresis ← DATA[3:0]. Legal only when DATA ≤ 15.
  - CMD 8'h03: mode ← DATA[1:0]. Legal only when DATA ≤ 2.
  - Any other CMD, or any out-of-range DATA, is error code 3.
- FSM states: IDLE, GET_CMD, GET_DATA, GET_CHK, APPLY.
  - IDLE: a byte equal to `HEADER` moves to GET_CMD. Any other byte is dropped silently.
  - GET_CMD: the next byte is latched as CMD; move to GET_DATA.
  - GET_DATA: the next byte is latched as DATA; move to GET_CHK.
  - GET_CHK: the next byte is latched as CHK; move to APPLY.
  - APPLY: lasts exactly one cycle and always returns to IDLE.
    - Checksum mismatch: error code 1.
    - Checksum correct but command or value illegal: error code 3.
    - Otherwise write the selected register and pulse `cfg_update`.
- Checksum is checked before the command. A frame that has both faults reports code 1.
- No resynchronisation inside a frame. A `HEADER` value arriving as CMD, DATA or CHK is treated as ordinary data.
- Timeout counter (24-bit):
  - Cleared on every accepted byte and whenever the state is IDLE.
  - Increments on every cycle in GET_CMD, GET_DATA or GET_CHK without `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`−1, the frame is abandoned: return to IDLE, pulse `err_pulse`, set `err_code` = 2.
- Simultaneous timeout and `rx_valid` in the same cycle: the byte wins, and the counter clears.
- A `rx_valid` during APPLY is handled exactly as it would be in IDLE. If that byte is `HEADER`, the next state is GET_CMD.
- A valid write of a value equal to the current one still pulses `cfg_update`.
- Reset mid-frame:
  - Returns to IDLE and discards the partial frame.
  - Restores all outputs to their reset values.
  - Does not pulse `err_pulse`.

## Timing
- All outputs are registered.
- Let E be the clock edge that samples the CHK byte (`rx_valid` = 1).
  - The state is APPLY after E.
  - The register update and `cfg_update` or `err_pulse` appear after edge E+1, i.e. 2 edges after the CHK strobe.
- Timeout: the error pulse appears `TIMEOUT_CYCLES` edges after the last accepted byte. `busy` drops on the same edge.
- `busy` rises on the edge that samples `HEADER` in IDLE. It falls on the edge that leaves APPLY or times out.
- `rx_valid` is accepted on any cycle, back-to-back included. The block never stalls and has no input backpressure.

## Test plan
- Reset, then idle: setpoint = 25, hysteresis = 2, mode = 1, `busy`/`cfg_update`/`err_pulse` = 0, `err_code` = 0.
- Setpoint write: bytes A5 01 1E C4 → setpoint = 30 and one `cfg_update` pulse 2 edges after the C4 strobe; no `err_pulse`. Then A5 02 05 AC → hysteresis = 5. Then A5 03 02 AA → mode = 2.
- Checksum and value errors:
  - A5 01 1E 00 → `err_code` = 1 with a single `err_pulse`; setpoint unchanged.
  - A5 01 3C E2 (60 > `SP_MAX`) → `err_code` = 3.
  - A5 07 00 AC → `err_code` = 3.
- Boundaries: A5 01 0A B0 (value 10) and A5 01 32 D8 (value 50) are both accepted. A5 01 09 AF (value 9) → `err_code` = 3.
- Timeout, with `TIMEOUT_CYCLES` = 100: send A5 01, then silence → `err_pulse` with `err_code` = 2 exactly 100 edges after the 01 strobe. A subsequent full valid frame is then accepted.
- Robustness:
  - Garbage bytes 00 FF 5A before a valid frame are dropped, and the frame is applied.
  - Back-to-back strobes on consecutive cycles are accepted.
  - Assert `reset` after A5 01 → IDLE, no error pulse, all outputs at reset values.

Source files
------------

// File: rtl/uart_cmd_controller.sv
// Assembles HEADER/CMD/DATA/CHK frames from the UART byte stream and applies them to the config registers.
// Outputs update two edges after the CHK strobe; no input backpressure (a byte is accepted on every cycle).
module uart_cmd_controller #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         SP_MIN         = 10,
  parameter int         SP_MAX         = 50,
  parameter int         SP_RESET       = 25,
  parameter int         HYST_RESET     = 2,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] setpoint,
  output logic [3:0] hysteresis,
  output logic [1:0] mode,
  output logic       cfg_update,
  output logic       err_pulse,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0]  SP_LO   = 8'(SP_MIN);
  localparam logic [7:0]  SP_HI   = 8'(SP_MAX);
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_DATA, GET_CHK, APPLY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d, data_q, data_d, chk_q, chk_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  sp_d;
  logic [3:0]  hy_d;
  logic [1:0]  md_d, ec_d;
  logic        cfg_d, err_d;
  logic [7:0]  sum;
  logic        cmd_ok;

  assign sum = HEADER + cmd_q + data_q;

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_q)
      8'h01:   cmd_ok = (data_q >= SP_LO) && (data_q <= SP_HI);
      8'h02:   cmd_ok = (data_q <= 8'd15);
      8'h03:   cmd_ok = (data_q <= 8'd2);
      default: cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    chk_d   = chk_q;
    cnt_d   = '0;
    sp_d    = setpoint;
    hy_d    = hysteresis;
    md_d    = mode;
    ec_d    = err_code;
    cfg_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, APPLY: begin
        if (state_q == APPLY) begin
          // Checksum takes priority over command legality.
          if (sum != chk_q) begin
            err_d = 1'b1;
            ec_d  = 2'd1;
          end else if (!cmd_ok) begin
            err_d = 1'b1;
            ec_d  = 2'd3;
          end else begin
            cfg_d = 1'b1;
            case (cmd_q)
              8'h01:   sp_d = data_q;
              8'h02:   hy_d = data_q[3:0];
              default: md_d = data_q[1:0];
            endcase
          end
        end
        state_d = (rx_valid && rx_data == HEADER) ? GET_CMD : IDLE;
      end
      GET_CMD, GET_DATA, GET_CHK: begin
        // A byte arriving on the timeout cycle still wins.
        if (rx_valid) begin
          case (state_q)
            GET_CMD:  begin cmd_d  = rx_data; state_d = GET_DATA; end
            GET_DATA: begin data_d = rx_data; state_d = GET_CHK;  end
            default:  begin chk_d  = rx_data; state_d = APPLY;    end
          endcase
        end else if (cnt_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          ec_d    = 2'd2;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      cnt_q      <= '0;
      setpoint   <= 8'(SP_RESET);
      hysteresis <= 4'(HYST_RESET);
      mode       <= 2'd1;
      cfg_update <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      cnt_q      <= cnt_d;
      setpoint   <= sp_d;
      hysteresis <= hy_d;
      mode       <= md_d;
      cfg_update <= cfg_d;
      err_pulse  <= err_d;
      err_code   <= ec_d;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Randomised and directed frame stimulus for uart_cmd_controller, checked against a frame-level model.
module tb_uart_cmd_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] setpoint;
  logic [3:0] hysteresis;
  logic [1:0] mode;
  logic       cfg_update, err_pulse, busy;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_cmd_controller #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .setpoint(setpoint), .hysteresis(hysteresis), .mode(mode),
    .cfg_update(cfg_update), .err_pulse(err_pulse), .err_code(err_code), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_e = 0;
  int cfg_cnt = 0, err_cnt = 0, cfg_cyc = 0, err_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cfg_update) begin cfg_cnt++; cfg_cyc = cyc; end
    if (err_pulse)  begin err_cnt++; err_cyc = cyc; end
  end

  // Frame-level model of the configuration state
  logic [7:0] m_sp = 8'd25;
  logic [3:0] m_hy = 4'd2;
  logic [1:0] m_md = 2'd1, m_ec = 2'd0;

  function automatic logic [1:0] expect_code(logic [7:0] c, logic [7:0] d, logic [7:0] k);
    int s;
    s = (165 + int'(c) + int'(d)) % 256;
    if (s != int'(k)) return 2'd1;
    if (c == 8'd1 && d >= 8'd10 && d <= 8'd50) return 2'd0;
    if (c == 8'd2 && d < 8'd16) return 2'd0;
    if (c == 8'd3 && d < 8'd3) return 2'd0;
    return 2'd3;
  endfunction

  task automatic model_frame(input logic [7:0] c, d, k, output int e_cfg, output int e_err);
    logic [1:0] code;
    code = expect_code(c, d, k);
    e_cfg = (code == 2'd0) ? 1 : 0;
    e_err = 1 - e_cfg;
    if (code != 2'd0) m_ec = code;
    else if (c == 8'd1) m_sp = d;
    else if (c == 8'd2) m_hy = d[3:0];
    else m_md = d[1:0];
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_e = cyc;
  endtask

  task automatic idle(input int g);
    repeat (g) @(posedge clk);
    if (g > 0) #1;
  endtask

  // Sends one frame and reports pulse deltas plus pulse latency from the CHK sampling edge.
  task automatic send_frame(input logic [7:0] c, d, k, input int gap,
                            output int d_cfg, output int d_err, output int lat);
    int c0, e0, e;
    c0 = cfg_cnt; e0 = err_cnt;
    send_byte(8'hA5); idle(gap);
    send_byte(c);     idle(gap);
    send_byte(d);     idle(gap);
    send_byte(k);
    e = last_e;
    idle(4);
    d_cfg = cfg_cnt - c0;
    d_err = err_cnt - e0;
    if (d_cfg + d_err != 1) lat = -1;
    else lat = (d_cfg == 1) ? cfg_cyc - e : err_cyc - e;
  endtask

  task automatic run_checked(input string name, input logic [7:0] c, d, k, input int gap);
    int dc, de, lat, ec, ee;
    logic [40:0] got, exp_v;
    send_frame(c, d, k, gap, dc, de, lat);
    model_frame(c, d, k, ec, ee);
    got   = {setpoint, hysteresis, mode, err_code, busy, 8'(dc), 8'(de), 8'(lat)};
    exp_v = {m_sp, m_hy, m_md, m_ec, 1'b0, 8'(ec), 8'(ee), 8'd1};
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s frame %h %h %h: got %h expected %h", name, c, d, k, got, exp_v);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);
    n_cmp++;
    if ({setpoint, hysteresis, mode, err_code, busy, cfg_update, err_pulse} !==
        {8'd25, 4'd2, 2'd1, 2'd0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state: got sp=%0d hy=%0d md=%0d ec=%0d busy=%b cfg=%b err=%b",
               setpoint, hysteresis, mode, err_code, busy, cfg_update, err_pulse);
    end
  endtask

  task automatic test_directed;
    logic [23:0] tbl [9] = '{24'h011EC4, 24'h0205AC, 24'h0302AA, 24'h011E00, 24'h013CE2,
                             24'h0700AC, 24'h010AB0, 24'h0132D8, 24'h0109AF};
    for (int i = 0; i < 9; i++) begin
      logic [23:0] f;
      f = tbl[i];
      run_checked("directed", f[23:16], f[15:8], f[7:0], 0);
      if (i == 0) begin
        n_cmp++;
        if (setpoint !== 8'd30) begin
          n_bad++;
          $display("FAIL setpoint_30: got %0d expected 30", setpoint);
        end
      end
    end
  endtask

  task automatic test_timeout;
    int e, c0;
    bit seen;
    c0 = cfg_cnt;
    seen = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h01);
    e = last_e;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_pulse) begin seen = 1'b1; break; end
    end
    m_ec = 2'd2;
    n_cmp++;
    if (!seen || cyc - e != 100 || err_code !== 2'd2 || busy !== 1'b0 ||
        setpoint !== m_sp || cfg_cnt != c0) begin
      n_bad++;
      $display("FAIL timeout: seen=%0d latency=%0d (need 100) ec=%0d busy=%b sp=%0d cfg=%0d",
               seen, cyc - e, err_code, busy, setpoint, cfg_cnt - c0);
    end
    @(posedge clk); #1;
    run_checked("after_timeout", 8'h01, 8'h14, 8'hBA, 0);
    // 99 idle cycles between bytes: the byte lands on the timeout cycle and must win.
    run_checked("gap_boundary", 8'h02, 8'h07, 8'hAE, 99);
  endtask

  task automatic test_garbage;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    idle(2);
    run_checked("garbage", 8'h01, 8'h1C, 8'hC2, 0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d1, d2;
    int c0, ec, ee, tot;
    d1 = 8'($urandom_range(10, 50));
    d2 = 8'($urandom_range(0, 15));
    c0 = cfg_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(d1); send_byte(8'hA5 + 8'h01 + d1);
    send_byte(8'hA5); send_byte(8'h02); send_byte(d2); send_byte(8'hA5 + 8'h02 + d2);
    idle(4);
    model_frame(8'h01, d1, 8'hA5 + 8'h01 + d1, ec, ee);
    tot = ec;
    model_frame(8'h02, d2, 8'hA5 + 8'h02 + d2, ec, ee);
    tot += ec;
    n_cmp++;
    if (cfg_cnt - c0 != tot || setpoint !== m_sp || hysteresis !== m_hy || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back: cfg=%0d/%0d sp=%0d/%0d hy=%0d/%0d busy=%b",
               cfg_cnt - c0, tot, setpoint, m_sp, hysteresis, m_hy, busy);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c, d, k;
      int r;
      r = int'($urandom_range(0, 4));
      c = (r == 0) ? 8'($urandom) : (r == 4 ? 8'd1 : 8'(r));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
      k = 8'hA5 + c + d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      run_checked("random", c, d, k, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_midframe;
    int e0, c0;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_midframe: got %b expected 1", busy);
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    m_sp = 8'd25; m_hy = 4'd2; m_md = 2'd1; m_ec = 2'd0;
    n_cmp++;
    if ({setpoint, hysteresis, mode, err_code, busy} !== {m_sp, m_hy, m_md, m_ec, 1'b0} ||
        err_cnt != e0) begin
      n_bad++;
      $display("FAIL reset_midframe: sp=%0d hy=%0d md=%0d ec=%0d busy=%b errs=%0d",
               setpoint, hysteresis, mode, err_code, busy, err_cnt - e0);
    end
    c0 = cfg_cnt;
    send_byte(8'h1E);
    send_byte(8'hC4);
    idle(4);
    n_cmp++;
    if (setpoint !== 8'd25 || cfg_cnt != c0 || err_cnt != e0) begin
      n_bad++;
      $display("FAIL discarded_tail: sp=%0d cfg=%0d err=%0d", setpoint, cfg_cnt - c0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_garbage;
    test_back_to_back;
    test_random;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
